pipelined_nbit_adder: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor for the multiplier datapath. It generalises the fixed-width combinational adders to any WIDTH. The carry chain is cut into SEG-bit segments with one register stage per segment. It adds a valid/ready stream handshake with backpressure, carry-in, an add/sub mode, and carry-out and signed-overflow flags. It sits between partial-product generation and the final product register in the 16x16 and 32x32 multipliers, and sustains one operation per cycle.

---
 rtl/pipelined_nbit_adder.sv | 111 +++++++++++
 tb/tb_pipelined_nbit_adder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_nbit_adder.sv
// rtl/pipelined_nbit_adder.sv - pipelined ripple-carry adder/subtractor with a valid/ready stream
// One SEG-bit carry segment is resolved per register stage; all stages advance together.
module pipelined_nbit_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int STAGES = WIDTH / SEG;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Subtraction is folded into the operands once, so every stage is a plain adder.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = k * SEG;
    localparam int PEND = WIDTH - LO;

    logic [PEND-1:0]   in_a;
    logic [PEND-1:0]   in_b;
    logic              in_c;
    logic              in_v;
    logic [SEG:0]      seg_sum;
    logic [LO+SEG-1:0] sum_d;
    logic [LO+SEG-1:0] s_q;
    logic              c_q;
    logic              v_q;

    assign seg_sum = {1'b0, in_a[SEG-1:0]} + {1'b0, in_b[SEG-1:0]} + {{SEG{1'b0}}, in_c};

    if (k == 0) begin : g_head
      assign in_a  = a;
      assign in_b  = b_eff;
      assign in_c  = c0;
      assign in_v  = in_valid;
      assign sum_d = seg_sum[SEG-1:0];
    end else begin : g_body
      assign in_a  = g_stage[k-1].g_pass.a_q;
      assign in_b  = g_stage[k-1].g_pass.b_q;
      assign in_c  = g_stage[k-1].c_q;
      assign in_v  = g_stage[k-1].v_q;
      assign sum_d = {seg_sum[SEG-1:0], g_stage[k-1].s_q};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= in_v;
        c_q <= seg_sum[SEG];
        s_q <= sum_d;
      end
    end

    // Operand bits not yet consumed travel with their carry to the next stage.
    if (PEND > SEG) begin : g_pass
      logic [PEND-SEG-1:0] a_q;
      logic [PEND-SEG-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= in_a[PEND-1:SEG];
          b_q <= in_b[PEND-1:SEG];
        end
      end
    end

    if (k == STAGES - 1) begin : g_tail
      logic ov_q;

      // The last segment holds the operand MSBs, so overflow is decided here.
      always_ff @(posedge clk) begin
        if (rst) begin
          ov_q <= 1'b0;
        end else if (adv) begin
          ov_q <= (in_a[SEG-1] == in_b[SEG-1]) && (seg_sum[SEG-1] != in_a[SEG-1]);
        end
      end

      assign out_valid = v_q;
      assign sum       = s_q;
      assign cout      = c_q;
      assign overflow  = ov_q;
    end
  end

endmodule

// File: tb/tb_pipelined_nbit_adder.sv
// tb/tb_pipelined_nbit_adder.sv - directed self-checking bench for pipelined_nbit_adder
// Main instance is 16/4; four more instances cover other WIDTH/SEG shapes.
module tb_pipelined_nbit_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  logic        sw_valid;
  logic        sw_ready;
  logic        sw_sub;
  logic        sw_cin;
  logic [47:0] sw_a [4];
  logic [47:0] sw_b [4];
  logic [49:0] sw_exp [4];
  wire  [3:0]  sw_rdy;
  wire  [3:0]  sw_vld;
  wire  [3:0]  sw_co;
  wire  [3:0]  sw_ov;
  wire  [7:0]  s8;
  wire  [23:0] s24;
  wire  [31:0] s32;
  wire  [47:0] s48;

  int wid [4] = '{8, 24, 32, 48};
  int lat [4] = '{1, 6, 4, 3};

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] op_a [128];
  logic [15:0] op_b [128];
  logic        op_c [128];
  logic        op_s [128];

  pipelined_nbit_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  pipelined_nbit_adder #(.WIDTH(8), .SEG(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy[0]),
    .a(sw_a[0][7:0]), .b(sw_b[0][7:0]), .cin(sw_cin), .sub(sw_sub),
    .out_valid(sw_vld[0]), .out_ready(sw_ready),
    .sum(s8), .cout(sw_co[0]), .overflow(sw_ov[0])
  );

  pipelined_nbit_adder #(.WIDTH(24), .SEG(4)) u24 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy[1]),
    .a(sw_a[1][23:0]), .b(sw_b[1][23:0]), .cin(sw_cin), .sub(sw_sub),
    .out_valid(sw_vld[1]), .out_ready(sw_ready),
    .sum(s24), .cout(sw_co[1]), .overflow(sw_ov[1])
  );

  pipelined_nbit_adder #(.WIDTH(32), .SEG(8)) u32 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy[2]),
    .a(sw_a[2][31:0]), .b(sw_b[2][31:0]), .cin(sw_cin), .sub(sw_sub),
    .out_valid(sw_vld[2]), .out_ready(sw_ready),
    .sum(s32), .cout(sw_co[2]), .overflow(sw_ov[2])
  );

  pipelined_nbit_adder #(.WIDTH(48), .SEG(16)) u48 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy[3]),
    .a(sw_a[3]), .b(sw_b[3]), .cin(sw_cin), .sub(sw_sub),
    .out_valid(sw_vld[3]), .out_ready(sw_ready),
    .sum(s48), .cout(sw_co[3]), .overflow(sw_ov[3])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, overflow, sum} of an w-bit add/sub, computed in wide arithmetic.
  function automatic logic [49:0] model(input int w, input logic [47:0] x, input logic [47:0] y,
                                        input logic s, input logic c);
    logic [63:0] mask, xx, be, t;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    xx   = {16'd0, x};
    be   = s ? (~{16'd0, y} & mask) : {16'd0, y};
    t    = xx + be + {63'd0, (s ? 1'b1 : c)};
    co   = t[w];
    ov   = (xx[w-1] == be[w-1]) && (t[w-1] != xx[w-1]);
    t    = t & mask;
    return {co, ov, t[47:0]};
  endfunction

  function automatic logic [47:0] corner(input int c, input int w);
    logic [63:0] v;
    if (c == 0)      v = 64'd0;
    else if (c == 1) v = (64'd1 << w) - 64'd1;
    else             v = 64'd1 << (w - 1);
    return v[47:0];
  endfunction

  function automatic logic [50:0] sw_get(input int i);
    case (i)
      0:       return {sw_vld[0], sw_co[0], sw_ov[0], 40'd0, s8};
      1:       return {sw_vld[1], sw_co[1], sw_ov[1], 24'd0, s24};
      2:       return {sw_vld[2], sw_co[2], sw_ov[2], 16'd0, s32};
      default: return {sw_vld[3], sw_co[3], sw_ov[3], s48};
    endcase
  endfunction

  task automatic single_op(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                           input logic xc, input logic xs,
                           input logic [15:0] es, input logic ec, input logic eo);
    a = xa; b = xb; cin = xc; sub = xs; out_ready = 1'b1; in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      chk({tag, "_out_valid"}, out_valid, (t == 4));
      if (t == 4) begin
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_overflow"}, overflow, eo);
      end
      @(posedge clk); #1;
    end
  endtask

  // Streams n ops from op_*; out_ready is low for slots [st_lo, st_hi).
  task automatic run_stream(input string tag, input int n, input int st_lo, input int st_hi);
    logic [49:0] q [$];
    logic [49:0] exp;
    logic [49:0] obs;
    logic        acc;
    int          sent;
    int          got;
    sent = 0;
    got  = 0;
    for (int t = 0; t < n + 40 && got < n; t++) begin
      out_ready = !(t >= st_lo && t < st_hi);
      #1;
      obs = {cout, overflow, 32'd0, sum};
      if (!out_ready) begin
        chk({tag, "_stall_in_ready"}, in_ready, 0);
        chk({tag, "_stall_out_valid"}, out_valid, 1);
        if (q.size() > 0) chk({tag, "_stall_hold"}, obs, q[0]);
      end
      if (st_hi == 0) chk({tag, "_out_valid"}, out_valid, (t >= 4 && t < n + 4));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk({tag, "_extra_result"}, 1, 0);
        end else begin
          exp = q.pop_front();
          chk($sformatf("%s_res%0d", tag, got), obs, exp);
          got++;
        end
      end
      if (sent < n) begin
        a = op_a[sent]; b = op_b[sent]; cin = op_c[sent]; sub = op_s[sent];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      if (acc) q.push_back(model(16, {32'd0, a}, {32'd0, b}, sub, cin));
      @(posedge clk); #1;
      if (acc) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_count"}, got, n);
    for (int t = 0; t < 5; t++) begin
      chk({tag, "_drained"}, out_valid, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [50:0] got;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_ready = 1'b1; sw_sub = 1'b0; sw_cin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sw_a[i] = '0;
      sw_b[i] = '0;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_sweep_valid", sw_vld, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_sweep_ready", sw_rdy, 4'hF);

    single_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    single_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    single_op("sub_borrow", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    single_op("add_cin_ovf", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    single_op("sub_cin_ignored", 16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

    for (int i = 0; i < 100; i++) begin
      op_a[i] = 16'($urandom);
      op_b[i] = 16'($urandom);
      op_c[i] = 1'($urandom_range(0, 1));
      op_s[i] = 1'($urandom_range(0, 1));
    end
    run_stream("stream", 100, 0, 0);

    op_a[0] = 16'h0001; op_b[0] = 16'h0002; op_c[0] = 1'b0; op_s[0] = 1'b0;
    op_a[1] = 16'h1000; op_b[1] = 16'h0FFF; op_c[1] = 1'b1; op_s[1] = 1'b0;
    op_a[2] = 16'h0000; op_b[2] = 16'h0001; op_c[2] = 1'b0; op_s[2] = 1'b1;
    op_a[3] = 16'h7FFF; op_b[3] = 16'h7FFF; op_c[3] = 1'b0; op_s[3] = 1'b0;
    op_a[4] = 16'h8000; op_b[4] = 16'h8000; op_c[4] = 1'b1; op_s[4] = 1'b0;
    op_a[5] = 16'hABCD; op_b[5] = 16'h1234; op_c[5] = 1'b0; op_s[5] = 1'b1;
    op_a[6] = 16'h00F0; op_b[6] = 16'h000F; op_c[6] = 1'b1; op_s[6] = 1'b0;
    op_a[7] = 16'h5555; op_b[7] = 16'hAAAA; op_c[7] = 1'b0; op_s[7] = 1'b1;
    run_stream("backpressure", 8, 4, 9);

    for (int i = 0; i < 3; i++) begin
      a = 16'h4000 + 16'(i); b = 16'h0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_sum", sum, 0);
    chk("rst_mid_cout", cout, 0);
    chk("rst_mid_overflow", overflow, 0);
    for (int t = 0; t < 6; t++) begin
      chk("rst_mid_flushed", out_valid, 0);
      @(posedge clk); #1;
    end
    single_op("post_rst_add", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

    for (int p = 0; p < 9; p++) begin
      sw_sub = ((p % 2) == 1);
      sw_cin = (((p / 2) % 2) == 1);
      for (int i = 0; i < 4; i++) begin
        sw_a[i]   = corner(p / 3, wid[i]);
        sw_b[i]   = corner(p % 3, wid[i]);
        sw_exp[i] = model(wid[i], sw_a[i], sw_b[i], sw_sub, sw_cin);
      end
      sw_valid = 1'b1;
      @(posedge clk); #1;
      sw_valid = 1'b0;
      for (int t = 1; t <= 7; t++) begin
        for (int i = 0; i < 4; i++) begin
          got = sw_get(i);
          chk($sformatf("sweep_w%0d_p%0d_valid_t%0d", wid[i], p, t), got[50], (t == lat[i]));
          if (t == lat[i]) chk($sformatf("sweep_w%0d_p%0d_result", wid[i], p), got[49:0], sw_exp[i]);
        end
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
